// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
package shift_add_pkg;

  localparam int unsigned N_BITS_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CLEAR,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned STATE_W = $bits(state_t);

endpackage

// File: rtl/shift_add_ctrl_iter_counter.sv
// Loadable down-counter tracking the remaining add/shift iterations.
module iter_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             one_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign one_o   = (count_q == CNT_W'(1));

endmodule

// File: rtl/shift_add_ctrl.sv
// Control FSM for the 8-bit shift-and-add multiplier; drives DATA_PATH register controls.
module shift_add_ctrl
  import shift_add_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_data_valid,
  input  logic A_out,
  output logic o_data_ready,
  output logic load_A,
  output logic load_B,
  output logic clr_ACC_reg,
  output logic load_ACC,
  output logic sel_SUM,
  output logic shift_A_reg,
  output logic o_busy,
  output logic o_done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_one;
  logic             cnt_load;
  logic             cnt_dec;

  // The non-zero guard keeps the counter from wrapping if RUN is ever entered unloaded.
  assign cnt_load = (state_q == ST_CLEAR);
  assign cnt_dec  = (state_q == ST_RUN) && (cnt != '0);

  iter_counter #(
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (CNT_W'(N_BITS)),
    .count_o    (cnt),
    .one_o      (cnt_one)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    o_data_ready = 1'b0;
    load_A       = 1'b0;
    load_B       = 1'b0;
    clr_ACC_reg  = 1'b0;
    load_ACC     = 1'b0;
    sel_SUM      = 1'b0;
    shift_A_reg  = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_d = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        o_data_ready = 1'b1;
        load_A       = i_data_valid;
        if (i_data_valid) state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        o_data_ready = 1'b1;
        load_B       = i_data_valid;
        if (i_data_valid) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_ACC_reg = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        load_ACC    = 1'b1;
        shift_A_reg = 1'b1;
        sel_SUM     = A_out;
        if (cnt_one) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        o_busy  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
